// File: rtl/bcd_counter_mod10.sv
// One decimal digit of a cascadable microwave-timer countdown.
// Loads saturate at 9 so the digit never leaves 0..9.
module bcd_counter_mod10 (
    input  logic       clk,
    input  logic       clrn,
    input  logic       loadn,
    input  logic       en,
    input  logic [3:0] data,
    output logic [3:0] out,
    output logic       tc,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] load_val;
    logic       at_zero;

    assign at_zero  = (cnt_q == 4'd0);
    assign load_val = (data > 4'd9) ? 4'd9 : data;

    always_comb begin
        cnt_d = cnt_q;
        if (!loadn) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = at_zero ? 4'd9 : (cnt_q - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A pending load blocks the borrow; reset overrides the load gate.
    assign tc   = en && at_zero && (loadn || !clrn);
    assign zero = at_zero;
    assign out  = cnt_q;

endmodule

// File: tb/tb_bcd_counter_mod10.sv
// Directed bench for bcd_counter_mod10: single digit plus
// a two-digit cascade driven from the low digit's borrow.
module tb_bcd_counter_mod10;

    logic       clk;
    logic       clrn;
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] out;
    logic       tc;
    logic       zero;

    logic       lo_loadn, lo_en, lo_tc, lo_zero;
    logic [3:0] lo_data, lo_out;
    logic       hi_loadn, hi_tc, hi_zero;
    logic [3:0] hi_data, hi_out;

    int total = 0;
    int bad   = 0;

    bcd_counter_mod10 u_dut (
        .clk   (clk),
        .clrn  (clrn),
        .loadn (loadn),
        .en    (en),
        .data  (data),
        .out   (out),
        .tc    (tc),
        .zero  (zero)
    );

    bcd_counter_mod10 u_lo (
        .clk   (clk),
        .clrn  (clrn),
        .loadn (lo_loadn),
        .en    (lo_en),
        .data  (lo_data),
        .out   (lo_out),
        .tc    (lo_tc),
        .zero  (lo_zero)
    );

    bcd_counter_mod10 u_hi (
        .clk   (clk),
        .clrn  (clrn),
        .loadn (hi_loadn),
        .en    (lo_tc),
        .data  (hi_data),
        .out   (hi_out),
        .tc    (hi_tc),
        .zero  (hi_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp;
        int tc_hits;
        int v;

        clrn     = 1'b0;
        loadn    = 1'b1;
        en       = 1'b0;
        data     = 4'd0;
        lo_loadn = 1'b1;
        lo_en    = 1'b0;
        lo_data  = 4'd0;
        hi_loadn = 1'b1;
        hi_data  = 4'd0;

        // reset hold
        repeat (4) step();
        chk("rst_out", {4'd0, out}, 8'd0);
        chk("rst_zero", {7'd0, zero}, 8'd1);
        chk("rst_tc", {7'd0, tc}, 8'd0);
        en = 1'b1;
        loadn = 1'b0;
        data = 4'd6;
        step();
        chk("rst_ign_load", {4'd0, out}, 8'd0);
        chk("rst_tc_en", {7'd0, tc}, 8'd1);
        en = 1'b0;
        loadn = 1'b1;

        // load 4 then count 20
        clrn  = 1'b1;
        loadn = 1'b0;
        data  = 4'd4;
        step();
        chk("ld4_out", {4'd0, out}, 8'd4);
        chk("ld4_zero", {7'd0, zero}, 8'd0);
        loadn = 1'b1;
        en    = 1'b1;
        exp   = 4;
        for (int i = 0; i < 20; i++) begin
            chk("cnt4_tc", {7'd0, tc}, (exp == 0) ? 8'd1 : 8'd0);
            step();
            exp = (exp == 0) ? 9 : exp - 1;
            chk("cnt4_out", {4'd0, out}, 8'(exp));
        end
        chk("cnt4_end", {4'd0, out}, 8'd4);

        // pause at 7, then async clear between edges
        loadn = 1'b0;
        data  = 4'd7;
        step();
        loadn = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold7", {4'd0, out}, 8'd7);
        end
        #2;
        clrn = 1'b0;
        #1;
        chk("async_clr", {4'd0, out}, 8'd0);
        chk("async_zero", {7'd0, zero}, 8'd1);
        step();
        clrn = 1'b1;
        step();
        chk("post_clr", {4'd0, out}, 8'd0);

        // load 5 while enabled, then 100 counts
        loadn = 1'b0;
        en    = 1'b1;
        data  = 4'd5;
        chk("ld5_tc_blk", {7'd0, tc}, 8'd0);
        step();
        chk("ld5_out", {4'd0, out}, 8'd5);
        loadn   = 1'b1;
        exp     = 5;
        tc_hits = 0;
        for (int i = 0; i < 100; i++) begin
            if (tc) tc_hits++;
            step();
            exp = (exp == 0) ? 9 : exp - 1;
            chk("cnt5_out", {4'd0, out}, 8'(exp));
        end
        chk("cnt5_end", {4'd0, out}, 8'd5);
        chk("cnt5_tc_hits", 8'(tc_hits), 8'd10);

        // load priority at zero, then saturation
        loadn = 1'b0;
        en    = 1'b0;
        data  = 4'd0;
        step();
        en   = 1'b1;
        data = 4'd2;
        chk("pri_zero", {7'd0, zero}, 8'd1);
        chk("pri_tc", {7'd0, tc}, 8'd0);
        step();
        chk("pri_out", {4'd0, out}, 8'd2);
        for (int d = 10; d < 16; d++) begin
            data = 4'(d);
            step();
            chk("sat_out", {4'd0, out}, 8'd9);
        end
        data = 4'd3;
        step();
        chk("ld3_out", {4'd0, out}, 8'd3);
        loadn = 1'b1;
        en    = 1'b0;

        // cascade 10 -> 09 ... 00 -> 99
        lo_loadn = 1'b0;
        hi_loadn = 1'b0;
        lo_data  = 4'd0;
        hi_data  = 4'd1;
        step();
        chk("cas_ld", {hi_out, lo_out}, 8'h10);
        lo_loadn = 1'b1;
        hi_loadn = 1'b1;
        lo_en    = 1'b1;
        v        = 10;
        for (int i = 0; i < 11; i++) begin
            step();
            v = (v == 0) ? 99 : v - 1;
            chk("cas_cnt", {hi_out, lo_out}, {4'(v / 10), 4'(v % 10)});
        end
        chk("cas_end", {hi_out, lo_out}, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_counter_mod10.md
BCD_COUNTER_MOD10 -- requirements
Module: bcd_counter_mod10

Interface
REQ-001 The module SHALL have no parameters; the digit range 0..9 is fixed.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all synchronous activity on its rising edge.
REQ-003 The module SHALL have port clrn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port loadn, input, 1 bit: synchronous parallel load, active-low.
REQ-005 The module SHALL have port en, input, 1 bit: count enable, active-high.
REQ-006 The module SHALL have port data, input, 4 bits: BCD value to load.
REQ-007 The module SHALL have port out, output, 4 bits: current BCD digit, registered.
REQ-008 The module SHALL have port tc, output, 1 bit: terminal count / borrow, for cascading to the next-higher digit.
REQ-009 The module SHALL have port zero, output, 1 bit: high while the digit equals 0.
REQ-010 The module SHALL use one clock (clk) and an asynchronous, active-low reset (clrn).

Function
REQ-011 The counter SHALL be a modulo-10 down counter (microwave timer digit).
REQ-012 Operation priority SHALL be clrn, then loadn, then en, then hold.
REQ-013 When loadn=0 at a rising edge, the counter SHALL set out to data on that edge, regardless of en.
REQ-014 When data is greater than 9, a load SHALL set out to 9, so out never holds a non-BCD code.
REQ-015 When loadn=1 and en=1 at a rising edge, the counter SHALL decrement out by 1, and SHALL go from 0 to 9 (wrap-around).
REQ-016 When loadn=1 and en=0, out SHALL hold its value.
REQ-017 zero SHALL be combinational: 1 if and only if out==0, independent of en.
REQ-018 tc SHALL be combinational: tc = en AND (out==0), so it is high exactly during the cycle whose edge wraps 0 to 9.
REQ-019 tc SHALL be 0 whenever loadn=0, because a load takes priority over counting.
REQ-020 Latency SHALL be: out changes one clock edge after a load or count condition; tc and zero follow out and en with no register delay.
REQ-021 out SHALL always lie in 0..9.

Reset
REQ-022 When clrn=0, out SHALL go to 0 immediately, without waiting for a clock edge.
REQ-023 While clrn=0, out SHALL stay at 0 and SHALL ignore loadn, en, data and clk.
REQ-024 During reset, zero SHALL be 1 and tc SHALL equal en.
REQ-025 If clrn is asserted mid-count, the counter SHALL abort the count; it SHALL resume from 0 on the first rising edge after clrn returns to 1.
REQ-026 clrn SHALL be released synchronously to clk.

Verification
REQ-027 Reset: clrn=0, en=0, loadn=1 for several cycles -> out=0, zero=1, tc=0.
REQ-028 Load then count from 4: apply clrn=1, loadn=0, data=4, en=0 for one edge -> out=4, zero=0. Then set en=1, loadn=1 -> successive edges give 3,2,1,0,9,8,... tc=1 only while out=0, and after 20 edges out=4.
REQ-029 Pause and async reset: with out=7, set en=0 for 10 edges -> out stays 7. Then pulse clrn=0 between clock edges -> out=0 immediately.
REQ-030 Load 5 and count: load data=5, then 100 enabled edges -> out sequence 4,3,2,1,0,9,...; after 100 edges out=5, and tc was high on exactly 10 of those edges.
REQ-031 Load priority and saturation: loadn=0, en=1, data=2 while out=0 -> out=2 on the next edge, and tc=0 during that cycle. Then load data=12 -> out=9.
REQ-032 Cascade: two instances, with the high digit's en driven by the low digit's tc; load 1 (high) and 0 (low), then count -> 10,09,08,...,00,99.
